rca_nibble_sequencer: RTL and testbench



---
 rtl/rca_nibble_sequencer.sv | 147 ++++++++++++++
 tb/tb_rca_nibble_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rca_nibble_sequencer.sv
// rca_nibble_sequencer
//   Runs a 4*NIBBLES-bit add through one external 4-bit ripple carry adder,
//   one nibble per clock. Operands are accepted with a valid/ready handshake
//   and held until the result has been retired on the output handshake.
//
//   Optional build macro: RCA_SEQ_SUBTRACT_EN. It adds the in_sub port, which
//   selects A-B, computed as A + ~B + 1.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     operand handshake
//   in_a, in_b, in_cin    operands and carry-in for slice 0
//   in_sub                subtract select (only with RCA_SEQ_SUBTRACT_EN)
//   add_a/add_b/add_cin   slice inputs driven to the external adder
//   add_sum/add_cout      slice outputs returned by the external adder
//   out_valid/out_ready   result handshake
//   out_sum, out_cout     assembled W-bit sum and final carry-out
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one slice per cycle through the adder, slice index = idx
// DONE  | result presented, held until out_ready
module rca_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
`ifdef RCA_SEQ_SUBTRACT_EN
  input  logic                 in_sub,
`endif
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic            carry_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [IW+1:0]   base;
  logic [3:0]      a_slice;
  logic [3:0]      b_slice;
  logic [3:0]      b_eff;
  logic            start_carry;

`ifdef RCA_SEQ_SUBTRACT_EN
  logic            sub_q;
  assign b_eff       = sub_q ? ~b_slice : b_slice;
  assign start_carry = in_sub ? 1'b1 : in_cin;
`else
  assign b_eff       = b_slice;
  assign start_carry = in_cin;
`endif

  // Bit offset of the current slice; only the registered idx selects slices.
  assign base    = {idx, 2'b00};
  assign a_slice = a_q[base +: 4];
  assign b_slice = b_q[base +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef RCA_SEQ_SUBTRACT_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= start_carry;
            idx        <= '0;
            result_q   <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
`ifdef RCA_SEQ_SUBTRACT_EN
            sub_q      <= in_sub;
`endif
          end
        end
        RUN: begin
          result_q[base +: 4] <= add_sum;
          carry_q             <= add_cout;
          if (idx == LAST) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            idx         <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // carry_q keeps its last value after retire, so the result side is gated.
  assign out_sum   = out_valid_q ? result_q : '0;
  assign out_cout  = out_valid_q & carry_q;

  assign add_a   = (state == RUN) ? a_slice : 4'h0;
  assign add_b   = (state == RUN) ? b_eff   : 4'h0;
  assign add_cin = (state == RUN) ? carry_q : 1'b0;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
module tb_rca_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  int n_cmp;
  int n_bad;

  rca_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef RCA_SEQ_SUBTRACT_EN
    .in_sub    (in_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  // Stand-in for the external 4-bit ripple carry adder.
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_sum !== 16'h0000) begin n_bad++; $display("FAIL reset_out_sum got=%h exp=0000", out_sum); end
    n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL reset_out_cout got=%b exp=0", out_cout); end
    n_cmp++; if ({add_a, add_b, add_cin} !== 9'h000) begin n_bad++; $display("FAIL reset_add_bus got=%h/%h/%b exp=0/0/0", add_a, add_b, add_cin); end
  endtask

  // Accepts one operation, checks every RUN cycle (slice A, running carry,
  // handshakes), the result, and the return to IDLE with out_ready high.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [N-1:0] exp_cin,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_accept_ready got=%b exp=1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_run%0d_hs got=%b%b exp=00", name, k, in_ready, out_valid); end
      n_cmp++; if (add_a !== a[4*k +: 4]) begin n_bad++; $display("FAIL %s_run%0d_add_a got=%h exp=%h", name, k, add_a, a[4*k +: 4]); end
      n_cmp++; if (add_cin !== exp_cin[k]) begin n_bad++; $display("FAIL %s_run%0d_add_cin got=%b exp=%b", name, k, add_cin, exp_cin[k]); end
      @(posedge clk); #1;
    end
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_done_hs got=%b%b exp=10", name, out_valid, in_ready); end
    n_cmp++; if (out_sum !== exp_sum) begin n_bad++; $display("FAIL %s_sum got=%h exp=%h", name, out_sum, exp_sum); end
    n_cmp++; if (out_cout !== exp_cout) begin n_bad++; $display("FAIL %s_cout got=%b exp=%b", name, out_cout, exp_cout); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_retire got=%b%b exp=01", name, out_valid, in_ready); end
  endtask

  task automatic test_basic();
    run_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 4'b0000, 16'h5555, 1'b0);
  endtask

  task automatic test_ripple();
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'b1110, 16'h0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4'b1111, 16'hFFFF, 1'b1);
    run_op("zeros", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_a = 16'h000F; in_b = 16'h0001; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N) begin @(posedge clk); #1; end
    // Offer new operands while the result is stalled; they must be ignored.
    in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp%0d_hs got=%b%b exp=10", c, out_valid, in_ready); end
      n_cmp++; if (out_sum !== 16'h0010 || out_cout !== 1'b0) begin n_bad++; $display("FAIL bp%0d_result got=%h/%b exp=0010/0", c, out_sum, out_cout); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_retire got=%b%b exp=01", out_valid, in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || add_a !== 4'h0) begin n_bad++; $display("FAIL bp_idle_stays got=%b/%h exp=1/0", in_ready, add_a); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_hs got=%b%b exp=01", out_valid, in_ready); end
    n_cmp++; if (out_sum !== 16'h0000 || add_a !== 4'h0 || add_cin !== 1'b0) begin n_bad++; $display("FAIL midrst_clear got=%h/%h/%b exp=0000/0/0", out_sum, add_a, add_cin); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 4'b0000, 16'h0007, 1'b0);
  endtask

`ifdef RCA_SEQ_SUBTRACT_EN
  task automatic test_subtract();
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 4'b0001, 16'hFFFE, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 4'b1111, 16'h0002, 1'b1);
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
`ifdef RCA_SEQ_SUBTRACT_EN
    test_subtract();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
